// File: rtl/endian_pkg.sv
// endian_pkg: byte-order helpers for 64-bit AXI-Stream beats (first wire byte in [7:0]).
package endian_pkg;
  function automatic logic [63:0] endian_conv64(input logic [63:0] d);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[8*i+:8] = d[8*(7-i)+:8];
    return r;
  endfunction
  function automatic logic [15:0] be16(input logic [63:0] d, input int i);
    return {d[8*i+:8], d[8*i+8+:8]};
  endfunction
endpackage

// File: rtl/ethernet_pkg.sv
// ethernet_pkg: Ethernet framing constants and the receive FSM state type.
package ethernet_pkg;
  localparam logic [15:0] ETH_P_IP = 16'h0800;
  localparam int ETH_HDR_LEN = 14;
  typedef enum logic [2:0] {SYNC, IDLE, HDR, TAIL, DROP} rx_state_t;
endpackage

// File: rtl/ip_pkg.sv
// ip_pkg: IPv4 header constants.
package ip_pkg;
  localparam logic [3:0] IPVERSION = 4'd4;
  localparam logic [7:0] IP4_PROTO_UDP = 8'd17;
  localparam int IP_HDR_LEN = 20;
  localparam logic [7:0] IP4_VER_IHL = {IPVERSION, 4'(IP_HDR_LEN / 4)};
endpackage

// File: rtl/udp_pkg.sv
// udp_pkg: UDP header constants.
package udp_pkg;
  localparam int UDP_HDR_LEN = 8;
endpackage

// File: rtl/ip_csum_acc.sv
// ip_csum_acc: 16-bit one's-complement accumulator fed by masked 64-bit beats.
module ip_csum_acc (
  input  logic        clk156,
  input  logic        reset_n,
  input  logic        clr,
  input  logic        add,
  input  logic [63:0] data,
  input  logic [7:0]  mask,
  output logic [15:0] sum
);
  logic [63:0] md;
  logic [18:0] raw;
  logic [16:0] f1;
  logic [15:0] nxt;
  always_comb begin
    md = '0;
    for (int i = 0; i < 8; i++) md[8*i+:8] = mask[i] ? data[8*i+:8] : 8'h00;
    raw = {3'b0, sum} + {3'b0, md[7:0], md[15:8]} + {3'b0, md[23:16], md[31:24]}
        + {3'b0, md[39:32], md[47:40]} + {3'b0, md[55:48], md[63:56]};
    f1 = {1'b0, raw[15:0]} + {14'b0, raw[18:16]};
    nxt = f1[15:0] + {15'b0, f1[16]};
  end
  always_ff @(posedge clk156 or negedge reset_n)
    if (!reset_n) sum <= '0;
    else if (clr) sum <= '0;
    else if (add) sum <= nxt;
endmodule

// File: rtl/eth_recv.sv
// eth_recv: filters IPv4/UDP frames for this host and reports source, port and first payload word.
module eth_recv
  import ethernet_pkg::*, ip_pkg::*, udp_pkg::*, endian_pkg::*;
#(
  parameter logic [47:0] eth_addr  = 48'h90_E2_BA_5D_8D_C8,
  parameter logic [31:0] ip_daddr  = {8'd192, 8'd168, 8'd1, 8'd122},
  parameter logic [15:0] udp_dport = 16'd3776
) (
  input  logic        clk156,
  input  logic        reset_n,
  input  logic        m_axis_rx_tvalid,
  input  logic [63:0] m_axis_rx_tdata,
  input  logic [7:0]  m_axis_rx_tkeep,
  input  logic        m_axis_rx_tlast,
  input  logic        m_axis_rx_tuser,
  output logic        pkt_valid,
  output logic [31:0] pkt_saddr,
  output logic [15:0] pkt_sport,
  output logic [63:0] pkt_payload,
  output logic [31:0] cnt_rx,
  output logic [31:0] cnt_ok,
  output logic [31:0] cnt_drop
);
  localparam int PAY_OFF = ETH_HDR_LEN + IP_HDR_LEN + UDP_HDR_LEN;
  localparam logic [2:0] PAY_B = 3'(PAY_OFF / 8);
  logic [1:0] rst_q;
  logic rst_s, vld, last, hdr, chk, bad, bad_now, accept, seen, csum_clr, csum_add;
  logic [2:0] bidx;
  logic [7:0] csum_mask;
  logic [15:0] csum, sport_q;
  logic [31:0] saddr_q;
  logic [63:0] d, pay_q;
  rx_state_t state, nxt;
  assign d = m_axis_rx_tdata;
  assign vld = m_axis_rx_tvalid;
  assign last = vld & m_axis_rx_tlast;
  assign hdr = vld & (state == HDR);
  assign rst_s = rst_q[1];
  // reset asserts immediately but releases two clk156 edges later
  always_ff @(posedge clk156 or negedge reset_n)
    if (!reset_n) rst_q <= '0;
    else rst_q <= {rst_q[0], 1'b1};
  always_ff @(posedge clk156 or negedge rst_s)
    if (!rst_s) state <= SYNC;
    else state <= nxt;
  always_comb
    nxt = !vld ? state
        : m_axis_rx_tlast ? IDLE
        : (state == IDLE) ? HDR
        : (state == HDR) ? (bad_now ? DROP : (bidx == 3'd6) ? TAIL : HDR)
        : state;
  always_comb begin
    chk = (bidx == 3'd0) ? ({be16(d, 0), be16(d, 2), be16(d, 4)} != eth_addr)
        : (bidx == 3'd1) ? ((be16(d, 4) != ETH_P_IP) | (d[55:48] != IP4_VER_IHL))
        : (bidx == 3'd2) ? (({d[37:32], d[47:40]} != 14'd0) | (d[63:56] != IP4_PROTO_UDP))
        : (bidx == 3'd3) ? (be16(d, 6) != ip_daddr[31:16])
        : (bidx == 3'd4) ? ((be16(d, 0) != ip_daddr[15:0]) | (be16(d, 4) != udp_dport))
        : 1'b0;
    bad_now = bad | chk;
    csum_clr = vld & (state == IDLE);
    csum_add = hdr & (bidx <= 3'd4);
    csum_mask = (bidx == 3'd1) ? 8'hC0 : (bidx == 3'd4) ? 8'h03 : 8'hFF;
    seen = last & (state != SYNC);
    accept = last & ((state == TAIL) | ((state == HDR) & (bidx == 3'd6) & !bad_now))
           & (csum == 16'hFFFF) & !m_axis_rx_tuser
           & ((bidx != 3'd6) | (m_axis_rx_tkeep >= 8'h03));
  end
  ip_csum_acc u_csum (
    .clk156 (clk156),
    .reset_n(rst_s),
    .clr    (csum_clr),
    .add    (csum_add),
    .data   (d),
    .mask   (csum_mask),
    .sum    (csum)
  );
  // payload bytes 0..7 straddle beats PAY_B (upper six bytes) and PAY_B+1 (lower two)
  always_ff @(posedge clk156 or negedge rst_s)
    if (!rst_s) begin
      bidx <= '0;
      bad <= 1'b0;
      saddr_q <= '0;
      sport_q <= '0;
      pay_q <= '0;
      pkt_valid <= 1'b0;
      pkt_saddr <= '0;
      pkt_sport <= '0;
      pkt_payload <= '0;
      cnt_rx <= '0;
      cnt_ok <= '0;
      cnt_drop <= '0;
    end else begin
      bidx <= !vld ? bidx : m_axis_rx_tlast ? 3'd0 : bidx + {2'b0, bidx != 3'd7};
      bad <= !vld ? bad : (state == IDLE) ? chk : bad_now;
      saddr_q <= (hdr & (bidx == 3'd3)) ? {d[23:16], d[31:24], d[39:32], d[47:40]} : saddr_q;
      sport_q <= (hdr & (bidx == 3'd4)) ? be16(d, 2) : sport_q;
      pay_q[47:0] <= (hdr & (bidx == PAY_B)) ? d[63:16] : pay_q[47:0];
      pay_q[63:48] <= (hdr & (bidx == PAY_B + 3'd1)) ? d[15:0] : pay_q[63:48];
      pkt_valid <= accept;
      if (accept) begin
        pkt_saddr <= saddr_q;
        pkt_sport <= sport_q;
        pkt_payload <= endian_conv64({(bidx == 3'd6) ? d[15:0] : pay_q[63:48], pay_q[47:0]});
      end
      if (seen) cnt_rx <= cnt_rx + 32'd1;
      if (accept) cnt_ok <= cnt_ok + 32'd1;
      if (seen & !accept) cnt_drop <= cnt_drop + 32'd1;
    end
endmodule

// File: tb/tb_eth_recv.sv
// tb_eth_recv: directed frames against eth_recv with hand-computed expectations.
module tb_eth_recv;
  localparam logic [47:0] MAC = 48'h90_E2_BA_5D_8D_C8;
  localparam logic [63:0] P1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] P2 = 64'hFEDC_BA98_7654_3210;
  logic clk156 = 1'b0;
  logic reset_n = 1'b0;
  logic m_axis_rx_tvalid = 1'b0;
  logic [63:0] m_axis_rx_tdata = '0;
  logic [7:0] m_axis_rx_tkeep = '0;
  logic m_axis_rx_tlast = 1'b0;
  logic m_axis_rx_tuser = 1'b0;
  logic pkt_valid;
  logic [31:0] pkt_saddr, cnt_rx, cnt_ok, cnt_drop;
  logic [15:0] pkt_sport;
  logic [63:0] pkt_payload;
  logic [7:0] fr [0:63];
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int p0;
  always #5 clk156 = ~clk156;
  eth_recv dut (
    .clk156          (clk156),
    .reset_n         (reset_n),
    .m_axis_rx_tvalid(m_axis_rx_tvalid),
    .m_axis_rx_tdata (m_axis_rx_tdata),
    .m_axis_rx_tkeep (m_axis_rx_tkeep),
    .m_axis_rx_tlast (m_axis_rx_tlast),
    .m_axis_rx_tuser (m_axis_rx_tuser),
    .pkt_valid       (pkt_valid),
    .pkt_saddr       (pkt_saddr),
    .pkt_sport       (pkt_sport),
    .pkt_payload     (pkt_payload),
    .cnt_rx          (cnt_rx),
    .cnt_ok          (cnt_ok),
    .cnt_drop        (cnt_drop)
  );
  always @(negedge clk156) if (pkt_valid) pulses++;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  // IPv4 checksum B6E9 is precomputed for the fixed header fields below
  task automatic build(input logic [47:0] dst, input logic [15:0] dport, input logic [63:0] pay, input logic [7:0] cx);
    logic [335:0] h;
    h = {dst, 48'h02_00_00_00_00_01, 16'h0800, 8'h45, 8'h00, 16'h002E, 16'h0001, 16'h4000,
         8'h40, 8'h11, 8'hB6, 8'hE9 ^ cx, 32'hC0A8_010A, 32'hC0A8_017A, 16'h0EC0, dport,
         16'h001A, 16'h0000};
    for (int i = 0; i < 64; i++)
      fr[i] = (i < 42) ? h[8*(41-i)+:8] : (i < 50) ? pay[8*(49-i)+:8] : 8'h00;
  endtask
  task automatic send(input int nbytes, input logic user, input int gap_b, input int from = 0, input int to = 99);
    for (int b = from; b < to && b * 8 < nbytes; b++) begin
      if (b == gap_b) begin
        m_axis_rx_tvalid = 1'b0;
        repeat (2) @(negedge clk156);
      end
      m_axis_rx_tvalid = 1'b1;
      for (int i = 0; i < 8; i++) begin
        m_axis_rx_tdata[8*i+:8] = (b * 8 + i < nbytes) ? fr[b*8+i] : 8'h00;
        m_axis_rx_tkeep[i] = (b * 8 + i < nbytes);
      end
      m_axis_rx_tlast = ((b + 1) * 8 >= nbytes);
      m_axis_rx_tuser = m_axis_rx_tlast & user;
      @(negedge clk156);
    end
    m_axis_rx_tvalid = 1'b0;
    m_axis_rx_tlast = 1'b0;
    m_axis_rx_tuser = 1'b0;
  endtask
  task automatic do_reset;
    reset_n = 1'b0;
    m_axis_rx_tvalid = 1'b0;
    @(negedge clk156);
    check("rst_valid", pkt_valid, 0);
    check("rst_cnt_rx", cnt_rx, 0);
    check("rst_cnt_ok", cnt_ok, 0);
    check("rst_cnt_drop", cnt_drop, 0);
    check("rst_payload", pkt_payload, 0);
    check("rst_saddr", pkt_saddr, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk156);
    send(8, 1'b0, -1);
    check("sync_discard", cnt_rx, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    do_reset;
    build(MAC, 16'd3776, P1, 8'h00);
    send(60, 1'b0, -1);
    check("ok_valid", pkt_valid, 1);
    check("ok_payload", pkt_payload, P1);
    check("ok_saddr", pkt_saddr, 32'hC0A8_010A);
    check("ok_sport", pkt_sport, 16'd3776);
    check("ok_cnt_ok", cnt_ok, 1);
    check("ok_cnt_rx", cnt_rx, 1);
    check("ok_cnt_drop", cnt_drop, 0);
    @(negedge clk156);
    check("ok_pulse_len", pkt_valid, 0);
    repeat (3) @(negedge clk156);
    check("ok_hold", pkt_payload, P1);
    do_reset;
    build(MAC, 16'd3776, P1, 8'h01);
    send(60, 1'b0, -1);
    check("csum_valid", pkt_valid, 0);
    check("csum_cnt_drop", cnt_drop, 1);
    check("csum_cnt_rx", cnt_rx, 1);
    check("csum_cnt_ok", cnt_ok, 0);
    check("csum_payload_hold", pkt_payload, 0);
    do_reset;
    build(MAC, 16'd3777, P1, 8'h00);
    send(60, 1'b0, -1);
    check("dport_valid", pkt_valid, 0);
    build(48'hFFFF_FFFF_FFFF, 16'd3776, P1, 8'h00);
    send(60, 1'b0, -1);
    check("bcast_valid", pkt_valid, 0);
    build(MAC, 16'd3776, P1, 8'h00);
    send(60, 1'b1, -1);
    check("tuser_valid", pkt_valid, 0);
    check("filt_cnt_drop", cnt_drop, 3);
    check("filt_cnt_ok", cnt_ok, 0);
    do_reset;
    p0 = pulses;
    build(MAC, 16'd3776, P1, 8'h00);
    send(60, 1'b0, 3);
    check("b2b_valid1", pkt_valid, 1);
    check("b2b_payload1", pkt_payload, P1);
    build(MAC, 16'd3776, P2, 8'h00);
    send(60, 1'b0, 3);
    check("b2b_valid2", pkt_valid, 1);
    check("b2b_payload2", pkt_payload, P2);
    @(negedge clk156);
    check("b2b_pulses", pulses - p0, 2);
    check("b2b_cnt_ok", cnt_ok, 2);
    do_reset;
    build(MAC, 16'd3776, P1, 8'h00);
    send(60, 1'b0, -1, 0, 4);
    reset_n = 1'b0;
    @(negedge clk156);
    check("midrst_valid", pkt_valid, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk156);
    send(60, 1'b0, -1, 5);
    check("midrst_rx", cnt_rx, 0);
    send(60, 1'b0, -1);
    check("midrst_next_valid", pkt_valid, 1);
    check("midrst_cnt_rx", cnt_rx, 1);
    check("midrst_cnt_ok", cnt_ok, 1);
    do_reset;
    build(MAC, 16'd3776, P1, 8'h00);
    send(8, 1'b0, -1);
    check("one_beat_valid", pkt_valid, 0);
    check("one_beat_drop", cnt_drop, 1);
    send(48, 1'b0, -1);
    check("b5_valid", pkt_valid, 0);
    check("b5_drop", cnt_drop, 2);
    send(49, 1'b0, -1);
    check("short_pay_valid", pkt_valid, 0);
    check("short_pay_drop", cnt_drop, 3);
    send(50, 1'b0, -1);
    check("b6_valid", pkt_valid, 1);
    check("b6_payload", pkt_payload, P1);
    check("b6_cnt_ok", cnt_ok, 1);
    force dut.cnt_drop = 32'hFFFF_FFFF;
    @(negedge clk156);
    release dut.cnt_drop;
    send(8, 1'b0, -1);
    check("drop_wrap", cnt_drop, 0);
    check("wrap_cnt_rx", cnt_rx, 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
